fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max WAIT cycles before abort (FP_ARB_TIMEOUT_EN only).

REQ-002 Ports SHALL be, one per line:
- Clock  in  1  single clock; all state updates on posedge.
- Reset  in  1  reset, synchronous and active-high.
- Req  in  NREQ  per-requester add request, held until granted.
- ReqA  in  NREQ*32  packed floats; requester i uses bits [32i+31:32i] (sign, 8-bit exponent, 23-bit fraction).
- ReqB  in  NREQ*32  second operand, same packing.
- Grant  out  NREQ  one-hot, one-cycle operand-accepted pulse.
- Done  out  NREQ  one-hot, one-cycle result-valid pulse.
- RespResult  out  32  result float, valid while Done is high, held until the next Done.
- RespZero / RespInf / RespNan  out  1 each  adder flags, same timing as RespResult.
- Busy  out  1  high whenever state != IDLE.
- TimeoutErr  out  1  sticky timeout flag.
- AddendA / AddendB  out  32 each  operands to the adder.
- Go  out  1  one-cycle adder start pulse.
- Result  in  32  adder result.
- Ready  in  1  adder completion level.
- Zero / Inf / Nan  in  1 each  adder flags.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT, RESP.
REQ-004 IDLE with any Req bit set SHALL select winner w by round-robin, register ReqA[w]/ReqB[w] into AddendA/AddendB, and go to LAUNCH.
REQ-005 IDLE with Req==0 SHALL stay in IDLE.
REQ-006 Round-robin SHALL search from pointer P upward modulo NREQ; after a grant to w, P SHALL become (w+1) mod NREQ, wrapping from NREQ-1 to 0.
REQ-007 LAUNCH SHALL last one cycle with Go=1 and Grant[w]=1, then go to WAIT.
REQ-008 Req SHALL NOT be sampled outside IDLE; operand changes after Grant SHALL NOT affect AddendA/AddendB.
REQ-009 AddendA/AddendB SHALL stay stable from LAUNCH until the FSM leaves RESP.
REQ-010 In the first WAIT cycle (blanking), Ready SHALL be ignored.
REQ-011 From the second WAIT cycle, Ready==1 SHALL latch Result/Zero/Inf/Nan and move the FSM to RESP.
REQ-012 RESP SHALL last one cycle with Done[w]=1 and registered response outputs, then return to IDLE.
REQ-013 Minimum latency from request to Done SHALL be 4 cycles: request sampled in cycle N, Grant/Go at N+1, blanking at N+2, Ready seen at N+3, Done at N+4.
REQ-014 Back-to-back service SHALL re-arbitrate in the IDLE cycle that follows RESP.
REQ-015 Grant and Done SHALL never have more than one bit set.
REQ-016 Go, Grant and Done SHALL never be high in the same cycle.

Reset
REQ-017 Reset SHALL force, on the next posedge, state=IDLE, P=0, Go=0, Grant=0, Done=0, Busy=0, RespResult=0, all Resp flags=0, AddendA=AddendB=0, TimeoutErr=0 and the WAIT counter to 0.
REQ-018 Reset during LAUNCH, WAIT or RESP SHALL discard the in-flight operation, issue no Done for it, and ignore Ready until a new LAUNCH.
REQ-019 Reset SHALL dominate every other same-cycle event.

Configuration
REQ-020 With FP_ARB_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; when it reaches TIMEOUT without Ready, the FSM SHALL enter RESP with RespResult=32'h7FC0_0000, RespNan=1, RespZero=RespInf=0, and TimeoutErr SHALL be set and held until Reset.
REQ-021 Ready arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, no timeout.
REQ-022 Without FP_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter logic SHALL exist, and TimeoutErr SHALL be tied to 0.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Req=4'b0001, A=32'h3F80_0000, B=32'h4000_0000, adder model returns 32'h4040_0000 three cycles after Go -> Grant[0] at N+1, exactly one Go, Done[0] with RespResult=32'h4040_0000.
- Req=4'b1111 held continuously after reset -> grant order 0,1,2,3,0; no requester granted twice before all others.
- A=B=32'h7F7F_FFFF, model returns 32'h7F80_0000 with Inf=1 -> RespInf=1 and RespResult=32'h7F80_0000 on the Done cycle.
- Reset pulsed in WAIT for requester 2, Req=4'b0110 pending -> no Done[2], Go low; first grant after reset goes to requester 1 (P=0).
- FP_ARB_TIMEOUT_EN defined, TIMEOUT=8, Ready stuck 0 -> Done after 8 WAIT cycles, RespResult=32'h7FC0_0000, RespNan=1, TimeoutErr=1 sticky until Reset.
- Macro undefined, Ready stuck 0 for 1000 cycles -> Busy=1 throughout, no Done, TimeoutErr=0.

Source files
------------

// File: rtl/fp_add_arbiter_if.sv
// fp_add_arbiter_if: requester-side and adder-side signals of the shared
// floating-point adder arbiter. The slave modport is the arbiter's view;
// the master modport is the view of whatever surrounds it (requesters + adder).
interface fp_add_arbiter_if #(
    parameter int NREQ = 4
);
    // Requester side
    logic [NREQ-1:0]    Req;
    logic [NREQ*32-1:0] ReqA;
    logic [NREQ*32-1:0] ReqB;
    logic [NREQ-1:0]    Grant;
    logic [NREQ-1:0]    Done;
    logic [31:0]        RespResult;
    logic               RespZero;
    logic               RespInf;
    logic               RespNan;
    logic               Busy;
    logic               TimeoutErr;

    // Adder side
    logic [31:0]        AddendA;
    logic [31:0]        AddendB;
    logic               Go;
    logic [31:0]        Result;
    logic               Ready;
    logic               Zero;
    logic               Inf;
    logic               Nan;

    modport slave (
        input  Req, ReqA, ReqB, Result, Ready, Zero, Inf, Nan,
        output Grant, Done, RespResult, RespZero, RespInf, RespNan,
               Busy, TimeoutErr, AddendA, AddendB, Go
    );

    modport master (
        output Req, ReqA, ReqB, Result, Ready, Zero, Inf, Nan,
        input  Grant, Done, RespResult, RespZero, RespInf, RespNan,
               Busy, TimeoutErr, AddendA, AddendB, Go
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one floating-point adder among NREQ requesters.
// Round-robin pick in IDLE, one-cycle LAUNCH (Go + Grant), WAIT for the
// adder (first WAIT cycle ignores Ready), one-cycle RESP (Done + result).
// Optional watchdog: define FP_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles with a quiet-NaN response and a sticky TimeoutErr.
module fp_add_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            Clock,
    input  logic            Reset,
    fp_add_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_config
        $error("fp_add_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;

    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   win_r;
    logic [PW-1:0]   pick_s;
    logic            pick_valid_s;
    logic            blank_r;
    logic            ready_ok_s;
    logic            timeout_hit_s;

    logic            go_r;
    logic            busy_r;
    logic [NREQ-1:0] grant_r;
    logic [NREQ-1:0] done_r;
    logic            go_next_s;
    logic            busy_next_s;
    logic [NREQ-1:0] grant_next_s;
    logic [NREQ-1:0] done_next_s;

    logic [31:0]     addend_a_r;
    logic [31:0]     addend_b_r;
    logic [31:0]     resp_result_r;
    logic            resp_zero_r;
    logic            resp_inf_r;
    logic            resp_nan_r;
    logic            timeout_err_r;

    // (base + offset) mod NREQ for offsets in 0..NREQ-1
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        sum = (sum >= NREQ) ? (sum - NREQ) : sum;
        return PW'(sum);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = {NREQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: walk offsets high to low so the nearest requester above the pointer wins.
    always_comb begin
        pick_s       = ptr_r;
        pick_valid_s = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.Req[rr_index(ptr_r, i)]) begin
                pick_s       = rr_index(ptr_r, i);
                pick_valid_s = 1'b1;
            end else begin
                pick_s       = pick_s;
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Ready only counts from the second WAIT cycle onward.
    assign ready_ok_s = (state_r == WAIT) && !blank_r && bus.Ready;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_r;

    // Counter holds the number of WAIT cycles already spent; a same-cycle Ready beats the timeout.
    assign timeout_hit_s = (state_r == WAIT) && !ready_ok_s &&
                           (wait_cnt_r == CW'(TIMEOUT - 1));

    // WAIT-cycle counter, cleared whenever the FSM is not staying in WAIT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (state_r == WAIT && state_next_s == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CW'(1'b1);
        end else begin
            wait_cnt_r <= {CW{1'b0}};
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // State register plus the registered control outputs derived from the next state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
            go_r    <= 1'b0;
            busy_r  <= 1'b0;
            grant_r <= {NREQ{1'b0}};
            done_r  <= {NREQ{1'b0}};
            blank_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            go_r    <= go_next_s;
            busy_r  <= busy_next_s;
            grant_r <= grant_next_s;
            done_r  <= done_next_s;
            blank_r <= (state_r == LAUNCH);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LAUNCH: state_next_s = WAIT;
            WAIT: begin
                if (ready_ok_s || timeout_hit_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from the next state, registered by the state register block.
    always_comb begin
        go_next_s    = 1'b0;
        busy_next_s  = 1'b0;
        grant_next_s = {NREQ{1'b0}};
        done_next_s  = {NREQ{1'b0}};
        case (state_next_s)
            IDLE: begin
                busy_next_s = 1'b0;
            end
            LAUNCH: begin
                go_next_s    = 1'b1;
                busy_next_s  = 1'b1;
                grant_next_s = onehot(pick_s);
            end
            WAIT: begin
                busy_next_s = 1'b1;
            end
            RESP: begin
                busy_next_s = 1'b1;
                done_next_s = onehot(win_r);
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Datapath: capture winner operands in IDLE, capture adder response (or timeout NaN) leaving WAIT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_r         <= {PW{1'b0}};
            win_r         <= {PW{1'b0}};
            addend_a_r    <= 32'h0000_0000;
            addend_b_r    <= 32'h0000_0000;
            resp_result_r <= 32'h0000_0000;
            resp_zero_r   <= 1'b0;
            resp_inf_r    <= 1'b0;
            resp_nan_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == IDLE && pick_valid_s) begin
                win_r      <= pick_s;
                ptr_r      <= rr_index(pick_s, 1);
                addend_a_r <= bus.ReqA[int'(pick_s) * 32 +: 32];
                addend_b_r <= bus.ReqB[int'(pick_s) * 32 +: 32];
            end
            if (ready_ok_s) begin
                resp_result_r <= bus.Result;
                resp_zero_r   <= bus.Zero;
                resp_inf_r    <= bus.Inf;
                resp_nan_r    <= bus.Nan;
            end else if (timeout_hit_s) begin
                resp_result_r <= 32'h7FC0_0000;
                resp_zero_r   <= 1'b0;
                resp_inf_r    <= 1'b0;
                resp_nan_r    <= 1'b1;
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign bus.Go         = go_r;
    assign bus.Grant      = grant_r;
    assign bus.Done       = done_r;
    assign bus.Busy       = busy_r;
    assign bus.AddendA    = addend_a_r;
    assign bus.AddendB    = addend_b_r;
    assign bus.RespResult = resp_result_r;
    assign bus.RespZero   = resp_zero_r;
    assign bus.RespInf    = resp_inf_r;
    assign bus.RespNan    = resp_nan_r;
    assign bus.TimeoutErr = timeout_err_r;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed + randomized bench for fp_add_arbiter with a
// cycle-counting reference (round-robin pick, latency from adder delay).
// Build with FP_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_fp_add_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fp_add_arbiter_if #(.NREQ(NREQ)) bus ();

    fp_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Requester drive
    logic [NREQ-1:0]    req_v = '0;
    logic [NREQ*32-1:0] a_pk  = '0;
    logic [NREQ*32-1:0] b_pk  = '0;
    assign bus.Req  = req_v;
    assign bus.ReqA = a_pk;
    assign bus.ReqB = b_pk;

    // Adder model: Ready rises (lat+1) cycles after the Go cycle and stays
    // high until the next Go; optional extra Ready pulse in the cycle after Go.
    logic [31:0] m_res    = 32'h0;
    logic        m_z      = 1'b0;
    logic        m_i      = 1'b0;
    logic        m_n      = 1'b0;
    int          m_lat    = 1;
    bit          m_glitch = 1'b0;
    bit          m_stuck  = 1'b0;
    int          m_cnt    = 0;
    logic        m_rdy    = 1'b0;
    assign bus.Ready  = m_rdy;
    assign bus.Result = m_res;
    assign bus.Zero   = m_z;
    assign bus.Inf    = m_i;
    assign bus.Nan    = m_n;

    // Adder latency model driven off the Go pulse.
    always @(posedge clk) begin
        if (bus.Go) begin
            m_cnt <= m_lat;
            m_rdy <= m_glitch;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
            m_rdy <= 1'b0;
        end else if (m_cnt == 1) begin
            m_cnt <= 0;
            m_rdy <= !m_stuck;
        end
    end

    int              p_model = 0;
    logic [NREQ-1:0] grant_log[$];

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++)
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_busy",   {31'd0, bus.Busy}, 32'd0);
        chk("rst_go",     {31'd0, bus.Go}, 32'd0);
        chk("rst_grant",  {28'd0, bus.Grant}, 32'd0);
        chk("rst_done",   {28'd0, bus.Done}, 32'd0);
        chk("rst_result", bus.RespResult, 32'd0);
        chk("rst_flags",  {29'd0, bus.RespZero, bus.RespInf, bus.RespNan}, 32'd0);
        chk("rst_addend_a", bus.AddendA, 32'd0);
        chk("rst_addend_b", bus.AddendB, 32'd0);
        chk("rst_timeout_err", {31'd0, bus.TimeoutErr}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        chk_reset_state();
        rst     = 1'b0;
        p_model = 0;
    endtask

    // One full transaction starting in an IDLE cycle with req_v already set.
    task automatic run_txn(input int lat, input bit glitch, input bit keep, input bit tmo,
                           input logic [31:0] res, input logic z, input logic i, input logic n);
        int          w;
        int          wait_cyc;
        logic [31:0] ea, eb, eres;
        logic [2:0]  eflags;
        w        = rr_pick(req_v, p_model);
        ea       = a_pk[32*w +: 32];
        eb       = b_pk[32*w +: 32];
        m_res    = res;
        m_z      = z;
        m_i      = i;
        m_n      = n;
        m_lat    = lat;
        m_glitch = glitch;
        eres     = tmo ? 32'h7FC0_0000 : res;
        eflags   = tmo ? 3'b001 : {z, i, n};
        wait_cyc = tmo ? TMO + 1 : lat + 2;

        step();
        grant_log.push_back(bus.Grant);
        chk("grant",        {28'd0, bus.Grant}, 32'd1 << w);
        chk("go_launch",    {31'd0, bus.Go}, 32'd1);
        chk("done_launch",  {28'd0, bus.Done}, 32'd0);
        chk("busy_launch",  {31'd0, bus.Busy}, 32'd1);
        chk("addend_a",     bus.AddendA, ea);
        chk("addend_b",     bus.AddendB, eb);
        p_model = (w + 1) % NREQ;
        if (!keep) req_v[w] = 1'b0;
        a_pk = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_pk = {$urandom(), $urandom(), $urandom(), $urandom()};

        for (int k = 1; k < wait_cyc; k++) begin
            step();
            chk("wait_done",     {28'd0, bus.Done}, 32'd0);
            chk("wait_go_grant", {27'd0, bus.Go, bus.Grant}, 32'd0);
            chk("wait_busy",     {31'd0, bus.Busy}, 32'd1);
        end

        step();
        chk("done",         {28'd0, bus.Done}, 32'd1 << w);
        chk("resp_result",  bus.RespResult, eres);
        chk("resp_flags",   {29'd0, bus.RespZero, bus.RespInf, bus.RespNan}, {29'd0, eflags});
        chk("addend_hold",  bus.AddendA, ea);
        chk("resp_go_grant", {27'd0, bus.Go, bus.Grant}, 32'd0);
        m_res = $urandom();
        m_z   = ~m_z;

        step();
        chk("done_clear", {28'd0, bus.Done}, 32'd0);
        chk("busy_idle",  {31'd0, bus.Busy}, 32'd0);
        chk("resp_hold",  bus.RespResult, eres);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        repeat (2) step();
        chk_reset_state();
        rst     = 1'b0;
        p_model = 0;

        // 1.0 + 2.0 = 3.0 on requester 0
        a_pk[31:0] = 32'h3F80_0000;
        b_pk[31:0] = 32'h4000_0000;
        req_v      = 4'b0001;
        run_txn(2, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b0);

        // Minimum latency: Done four cycles after the request is sampled
        req_v = 4'b0001;
        run_txn(1, 1'b0, 1'b0, 1'b0, $urandom(), 1'b1, 1'b0, 1'b0);

        // Ready pulse inside the blanking cycle must be ignored
        req_v = 4'b1000;
        run_txn(3, 1'b1, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b1);

        // Overflow to infinity
        a_pk[63:32] = 32'h7F7F_FFFF;
        b_pk[63:32] = 32'h7F7F_FFFF;
        req_v       = 4'b0010;
        run_txn(2, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 1'b0, 1'b1, 1'b0);

        // All four requesting continuously: order 0,1,2,3,0
        do_reset();
        req_v = 4'b1111;
        grant_log.delete();
        repeat (5) run_txn($urandom_range(1, 4), 1'b0, 1'b1, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++)
            chk("rr_order", {28'd0, grant_log[j]}, 32'd1 << (j % 4));
        req_v = 4'b0000;
        step();

        // Randomized masks, latencies and responses
        repeat (12) begin
            req_v = 4'($urandom_range(1, 15));
            a_pk  = {$urandom(), $urandom(), $urandom(), $urandom()};
            b_pk  = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_txn($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            req_v = 4'b0000;
        end

        // Pointer returns to 0 on reset: after a grant to 0, Req=1001 must pick 0 again
        req_v = 4'b0001;
        run_txn(2, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0);
        do_reset();
        req_v = 4'b1001;
        run_txn(2, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0);
        req_v = 4'b0000;
        step();

        // Reset while requester 2 is in WAIT with 0110 pending
        req_v    = 4'b0100;
        m_lat    = 6;
        m_glitch = 1'b0;
        step();
        chk("abort_grant", {28'd0, bus.Grant}, 32'd4);
        req_v = 4'b0110;
        step();
        chk("abort_wait_done", {28'd0, bus.Done}, 32'd0);
        step();
        chk("abort_wait_done2", {28'd0, bus.Done}, 32'd0);
        do_reset();
        run_txn(2, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0);
        run_txn(2, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0);

`ifdef FP_ARB_TIMEOUT_EN
        // Ready in the same cycle the watchdog expires: normal completion
        req_v = 4'b0001;
        run_txn(TMO - 1, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0);
        chk("tmo_race_err", {31'd0, bus.TimeoutErr}, 32'd0);
        // Adder never answers: quiet NaN after TMO WAIT cycles
        m_stuck = 1'b1;
        req_v   = 4'b0010;
        run_txn(3, 1'b0, 1'b0, 1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
        chk("tmo_err_set", {31'd0, bus.TimeoutErr}, 32'd1);
        m_stuck = 1'b0;
        req_v   = 4'b0100;
        run_txn(2, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b0, 1'b0);
        chk("tmo_err_sticky", {31'd0, bus.TimeoutErr}, 32'd1);
        do_reset();
`else
        // Adder never answers: WAIT indefinitely
        m_stuck = 1'b1;
        req_v   = 4'b0001;
        m_lat   = 2;
        step();
        chk("stuck_grant", {28'd0, bus.Grant}, 32'd1);
        req_v = 4'b0000;
        bad   = 0;
        repeat (1000) begin
            step();
            if (bus.Busy !== 1'b1 || bus.Done !== 4'b0000 || bus.TimeoutErr !== 1'b0) bad++;
        end
        chk("stuck_bad_cycles", bad, 32'd0);
        m_stuck = 1'b0;
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
